// File: rtl/fetch_queue.sv
// fetch_queue: pipelined instruction fetch with a prefetch FIFO and redirect handling.
// Defining FETCH_QUEUE_PERF_EN adds free-running request/discard/starvation counters.
module fetch_queue #(
  parameter logic [31:0] PC_RESET        = 32'h0,
  parameter int unsigned QUEUE_DEPTH     = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] main_memory_instr_addr,
  output logic        main_memory_instr_req,
  input  logic [31:0] main_memory_instr,
  input  logic        main_memory_instr_ack,
  output logic [31:0] fetch_instr,
  output logic [31:0] pc,
  output logic        next_clk_en,
  input  logic        writeback_change_pc,
  input  logic [31:0] writeback_next_pc,
  input  logic        execute_change_pc,
  input  logic [31:0] execute_next_pc,
  input  logic        stall,
  input  logic        flush
`ifdef FETCH_QUEUE_PERF_EN
  ,
  output logic [31:0] perf_req_count,
  output logic [31:0] perf_discard_count,
  output logic [31:0] perf_stall_count
`endif
);

  localparam int unsigned AW  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        fifo_mem [QUEUE_DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] discard;
  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   hold_pc;
  logic          run;

  logic          redirect;
  logic          ack_valid;
  logic          empty;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   target_raw;
  logic [31:0]   target;

  // Issue credits: in-flight plus buffered words never exceed the FIFO depth.
  always_comb begin
    redirect    = writeback_change_pc | execute_change_pc;
    target_raw  = writeback_change_pc ? writeback_next_pc : execute_next_pc;
    target      = target_raw & ~32'h3;
    ack_valid   = main_memory_instr_ack && (outstanding != '0);
    empty       = (count == '0);
    issue       = run && !redirect
                  && (32'(outstanding) < MAX_OUTSTANDING)
                  && ((32'(outstanding) + 32'(count)) < QUEUE_DEPTH);
    push        = ack_valid && (discard == '0) && !redirect;
    pop         = !empty && !stall && !redirect;
    next_clk_en = pop && !flush;
  end

  always_comb begin
    main_memory_instr_req  = issue;
    main_memory_instr_addr = fetch_pc;
    fetch_instr            = empty ? NOP : fifo_mem[rd_ptr].instr;
    pc                     = empty ? hold_pc : fifo_mem[rd_ptr].pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      fetch_pc    <= PC_RESET;
      resp_pc     <= PC_RESET;
      hold_pc     <= PC_RESET;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      run         <= 1'b1;
      outstanding <= outstanding + OW'(issue) - OW'(ack_valid);
      if (pop) hold_pc <= fifo_mem[rd_ptr].pc;
      if (redirect) begin
        // Every request still in flight after this edge belongs to the old path.
        fetch_pc <= target;
        resp_pc  <= target;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        discard  <= outstanding - OW'(ack_valid);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= wr_ptr + AW'(1);
        end
        if (pop) rd_ptr <= rd_ptr + AW'(1);
        if (ack_valid && (discard != '0)) discard <= discard - OW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr].pc    <= resp_pc;
      fifo_mem[wr_ptr].instr <= main_memory_instr;
    end
  end

`ifdef FETCH_QUEUE_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_req_count     <= '0;
      perf_discard_count <= '0;
      perf_stall_count   <= '0;
    end else begin
      perf_req_count     <= perf_req_count + 32'(issue);
      perf_discard_count <= perf_discard_count
                            + 32'(ack_valid && ((discard != '0) || redirect));
      perf_stall_count   <= perf_stall_count + 32'(empty && !stall);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: randomized and directed checks of fetch_queue against a queue-based model.
// The memory responder has a fixed, adjustable latency; perf counters checked under FETCH_QUEUE_PERF_EN.
`timescale 1ns/1ps
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned MAXO  = 2;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] main_memory_instr_addr;
  logic        main_memory_instr_req;
  logic [31:0] main_memory_instr = 32'h0;
  logic        main_memory_instr_ack = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] pc;
  logic        next_clk_en;
  logic        writeback_change_pc = 1'b0;
  logic [31:0] writeback_next_pc = 32'h0;
  logic        execute_change_pc = 1'b0;
  logic [31:0] execute_next_pc = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
`ifdef FETCH_QUEUE_PERF_EN
  logic [31:0] perf_req_count;
  logic [31:0] perf_discard_count;
  logic [31:0] perf_stall_count;
`endif

  fetch_queue #(.PC_RESET(32'h0), .QUEUE_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .main_memory_instr_addr(main_memory_instr_addr),
    .main_memory_instr_req(main_memory_instr_req),
    .main_memory_instr(main_memory_instr),
    .main_memory_instr_ack(main_memory_instr_ack),
    .fetch_instr(fetch_instr), .pc(pc), .next_clk_en(next_clk_en),
    .writeback_change_pc(writeback_change_pc), .writeback_next_pc(writeback_next_pc),
    .execute_change_pc(execute_change_pc), .execute_next_pc(execute_next_pc),
    .stall(stall), .flush(flush)
`ifdef FETCH_QUEUE_PERF_EN
    , .perf_req_count(perf_req_count), .perf_discard_count(perf_discard_count),
    .perf_stall_count(perf_stall_count)
`endif
  );

  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  // Memory responder: fixed latency, in-order, one ack per request.
  typedef struct {int due; logic [31:0] data;} mresp_t;
  logic [31:0] mem [256];
  mresp_t      mq [$];
  int          lat = 1;
  int          edge_n = 0;

  always @(posedge clk) begin : mem_proc
    mresp_t e;
    if (!rst_n) begin
      main_memory_instr_ack <= 1'b0;
      mq.delete();
    end else begin
      edge_n++;
      if (main_memory_instr_req) begin
        e.due  = edge_n + lat - 1;
        e.data = mem[main_memory_instr_addr[9:2]];
        mq.push_back(e);
      end
      if (mq.size() > 0 && mq[0].due <= edge_n) begin
        main_memory_instr_ack <= 1'b1;
        main_memory_instr     <= mq[0].data;
        mq.delete(0);
      end else begin
        main_memory_instr_ack <= 1'b0;
        main_memory_instr     <= $urandom;
      end
    end
  end

  // Reference model: requests in flight tagged stale on redirect, buffered words as a pc queue.
  typedef struct {logic [31:0] pc; bit stale;} inf_t;
  inf_t        infl [$];
  logic [31:0] fq [$];
  logic [31:0] m_fetch_pc = 32'h0;
  bit          m_run = 1'b0;
  int          m_reqs = 0;
  int          m_stall_cyc = 0;
  int          drops = 0;

  bit          c_st, c_redir, ack_s;
  logic [31:0] c_target;
  bit          exp_req, exp_valid, exp_en;
  logic [31:0] exp_addr, exp_pc, exp_instr;

  task automatic predict();
    c_st      = stall;
    c_redir   = writeback_change_pc | execute_change_pc;
    c_target  = (writeback_change_pc ? writeback_next_pc : execute_next_pc) & ~32'h3;
    exp_req   = m_run && !c_redir && (infl.size() < int'(MAXO))
                && (infl.size() + fq.size() < int'(DEPTH));
    exp_addr  = m_fetch_pc;
    exp_valid = (fq.size() != 0);
    exp_pc    = exp_valid ? fq[0] : 32'h0;
    exp_instr = mem[exp_pc[9:2]];
    exp_en    = exp_valid && !stall && !flush && !c_redir;
    ack_s     = main_memory_instr_ack;
    if (!exp_valid && !stall) m_stall_cyc++;
  endtask

  task automatic drive(input bit st, input bit fl, input bit ec, input logic [31:0] ep,
                       input bit wc, input logic [31:0] wp);
    @(negedge clk);
    stall = st; flush = fl;
    execute_change_pc = ec; execute_next_pc = ep;
    writeback_change_pc = wc; writeback_next_pc = wp;
    #1;
    predict();
  endtask

  task automatic advance();
    inf_t f, nf;
    bit acc;
    @(posedge clk);
    acc = ack_s && (infl.size() > 0);
    if (acc) f = infl.pop_front();
    if (exp_req) m_reqs++;
    if (c_redir) begin
      fq.delete();
      foreach (infl[i]) infl[i].stale = 1'b1;
      if (acc) drops++;
      m_fetch_pc = c_target;
    end else begin
      if (exp_valid && !c_st) fq.delete(0);
      if (acc) begin
        if (f.stale) drops++;
        else fq.push_back(f.pc);
      end
      if (exp_req) begin
        nf.pc = m_fetch_pc; nf.stale = 1'b0;
        infl.push_back(nf);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    m_run = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec += 5;
    if (main_memory_instr_req !== 1'b0) begin miss++; $display("FAIL rst_req got %0b exp 0", main_memory_instr_req); end
    if (main_memory_instr_addr !== 32'h0) begin miss++; $display("FAIL rst_addr got %h exp 0", main_memory_instr_addr); end
    if (pc !== 32'h0) begin miss++; $display("FAIL rst_pc got %h exp 0", pc); end
    if (fetch_instr !== NOP) begin miss++; $display("FAIL rst_instr got %h exp %h", fetch_instr, NOP); end
    if (next_clk_en !== 1'b0) begin miss++; $display("FAIL rst_en got %0b exp 0", next_clk_en); end
    rst_n = 1'b1;
    #1;
    predict();
    vec += 2;
    if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL rel_req got %0b exp %0b", main_memory_instr_req, exp_req); end
    if (next_clk_en !== exp_en) begin miss++; $display("FAIL rel_en got %0b exp %0b", next_clk_en, exp_en); end
    advance();
  endtask

  task automatic test_sequential();
    int presented = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 0, 32'h0, 0, 32'h0);
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL seq_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL seq_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL seq_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL seq_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL seq_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      if (next_clk_en === 1'b1) presented++;
      advance();
    end
    vec++;
    if (presented < 10) begin miss++; $display("FAIL seq_count got %0d exp >=10", presented); end
  endtask

  task automatic test_redirect();
    bit got = 1'b0;
    logic [31:0] first_pc = 32'h0;
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, (i == 0), 32'h10, 0, 32'h0);
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL redir_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL redir_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL redir_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL redir_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL redir_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      if (i > 0 && !got && next_clk_en === 1'b1) begin got = 1'b1; first_pc = pc; end
      advance();
    end
    vec++;
    if (!got || first_pc !== 32'h10) begin miss++; $display("FAIL redir_first got %h (seen %0b) exp 00000010", first_pc, got); end
  endtask

  task automatic test_priority();
    bit got = 1'b0;
    logic [31:0] first_pc = 32'h0;
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, (i == 0), 32'h40, (i == 0), 32'h18);
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL prio_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL prio_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL prio_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL prio_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL prio_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      if (i > 0 && !got && next_clk_en === 1'b1) begin got = 1'b1; first_pc = pc; end
      advance();
    end
    vec++;
    if (!got || first_pc !== 32'h18) begin miss++; $display("FAIL prio_first got %h (seen %0b) exp 00000018", first_pc, got); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 16; i++) begin
      drive((i < 6), 0, 0, 32'h0, 0, 32'h0);
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL stall_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL stall_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL stall_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL stall_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL stall_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      if (i == 5) begin
        vec++;
        if (main_memory_instr_req !== 1'b0) begin miss++; $display("FAIL stall_credit got req %0b exp 0", main_memory_instr_req); end
      end
      if (i >= 6 && i < 10) begin
        vec++;
        if (next_clk_en !== 1'b1) begin miss++; $display("FAIL stall_burst cycle %0d got %0b exp 1", i - 6, next_clk_en); end
      end
      advance();
    end
  endtask

  task automatic test_flush();
    bit done = 1'b0;
    bit got = 1'b0;
    bit fl;
    logic [31:0] next_pc = 32'h0;
    for (int i = 0; i < 16; i++) begin
      fl = !done && (i > 0) && (fq.size() != 0) && (fq[0] == 32'h8);
      drive(0, fl, (i == 0), 32'h0, 0, 32'h0);
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL flush_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL flush_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL flush_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL flush_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL flush_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      if (fl) begin
        done = 1'b1;
        vec++;
        if (next_clk_en !== 1'b0) begin miss++; $display("FAIL flush_kill got en %0b exp 0", next_clk_en); end
      end else if (done && !got && next_clk_en === 1'b1) begin
        got = 1'b1; next_pc = pc;
      end
      advance();
    end
    vec++;
    if (!got || next_pc !== 32'hC) begin miss++; $display("FAIL flush_next got %h (seen %0b) exp 0000000c", next_pc, got); end
  endtask

  task automatic test_latency();
    bit done = 1'b0;
    bit got = 1'b0;
    bit rd;
    logic [31:0] first_pc = 32'h0;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] disc0 = 32'h0;
`endif
    lat = 3;
    for (int i = 0; i < 50; i++) begin
      rd = !done && (i > 4) && (infl.size() == 2) && !infl[0].stale && !infl[1].stale;
      drive(0, 0, rd, 32'h20, 0, 32'h0);
`ifdef FETCH_QUEUE_PERF_EN
      if (rd) disc0 = perf_discard_count;
`endif
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL lat_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL lat_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL lat_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL lat_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL lat_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      if (done && !got && next_clk_en === 1'b1) begin got = 1'b1; first_pc = pc; end
      if (rd) done = 1'b1;
      advance();
    end
    vec++;
    if (!got || first_pc !== 32'h20) begin miss++; $display("FAIL lat_first got %h (seen %0b redirected %0b) exp 00000020", first_pc, got, done); end
`ifdef FETCH_QUEUE_PERF_EN
    @(negedge clk);
    vec++;
    if (perf_discard_count - disc0 !== 32'd2) begin miss++; $display("FAIL lat_discard got %0d exp 2", perf_discard_count - disc0); end
`endif
  endtask

  task automatic test_random(input int n);
    bit st, fl, ec, wc;
    logic [31:0] ep, wp;
    for (int i = 0; i < n; i++) begin
      st = ($urandom_range(0, 3) == 0);
      fl = ($urandom_range(0, 9) == 0);
      ec = ($urandom_range(0, 19) == 0);
      wc = ($urandom_range(0, 29) == 0);
      ep = 32'($urandom_range(0, 1023));
      wp = 32'($urandom_range(0, 1023));
      drive(st, fl, ec, ep, wc, wp);
      vec += 2;
      if (main_memory_instr_req !== exp_req) begin miss++; $display("FAIL rnd_req t=%0t got %0b exp %0b", $time, main_memory_instr_req, exp_req); end
      if (next_clk_en !== exp_en) begin miss++; $display("FAIL rnd_en t=%0t got %0b exp %0b", $time, next_clk_en, exp_en); end
      if (exp_req) begin vec++; if (main_memory_instr_addr !== exp_addr) begin miss++; $display("FAIL rnd_addr t=%0t got %h exp %h", $time, main_memory_instr_addr, exp_addr); end end
      if (exp_valid) begin
        vec += 2;
        if (pc !== exp_pc) begin miss++; $display("FAIL rnd_pc t=%0t got %h exp %h", $time, pc, exp_pc); end
        if (fetch_instr !== exp_instr) begin miss++; $display("FAIL rnd_instr t=%0t got %h exp %h", $time, fetch_instr, exp_instr); end
      end
      advance();
    end
  endtask

`ifdef FETCH_QUEUE_PERF_EN
  task automatic test_perf();
    @(negedge clk);
    vec += 3;
    if (perf_req_count !== 32'(m_reqs)) begin miss++; $display("FAIL perf_req got %0d exp %0d", perf_req_count, m_reqs); end
    if (perf_discard_count !== 32'(drops)) begin miss++; $display("FAIL perf_discard got %0d exp %0d", perf_discard_count, drops); end
    if (perf_stall_count !== 32'(m_stall_cyc)) begin miss++; $display("FAIL perf_stall got %0d exp %0d", perf_stall_count, m_stall_cyc); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    test_reset();
    test_sequential();
    test_redirect();
    test_priority();
    test_stall();
    test_flush();
    test_random(300);
    test_latency();
    test_random(300);
`ifdef FETCH_QUEUE_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
